// File: rtl/if_fetch_unit_if.sv
// SRAM-like instruction-read channel between the fetch stage and instruction memory.
// Request side is valid/ready (req/addr_ok); the response side is a single data_ok strobe.
interface if_fetch_unit_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one outstanding SRAM read, a one-entry {pc, inst} buffer toward decode,
// and branch redirect that squashes the buffer and any response still in flight.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ID_Allow_in,
  input  logic [33:0]     br_bus,
  output logic            IF_to_ID_Valid,
  output logic [63:0]     IF_to_ID_Bus,
  if_fetch_unit_if.master inst_sram
);

  typedef enum logic {
    S_REQ,
    S_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] req_pc, req_pc_nxt;
  logic        cancel, cancel_nxt;
  logic        buf_valid, buf_valid_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] buf_inst, buf_inst_nxt;

  logic        br_taken;
  logic [31:0] br_target;
  logic        unused_stall;
  logic        drain;
  logic        addr_hs;
  logic        data_ret;

  assign br_taken     = br_bus[33];
  assign br_target    = br_bus[32:1];
  assign unused_stall = br_bus[0];

  assign drain    = buf_valid & ID_Allow_in & ~br_taken;
  assign addr_hs  = inst_sram.req & inst_sram.addr_ok;
  assign data_ret = (state == S_WAIT) & inst_sram.data_ok;

  // resetn gates req so the bus is quiet while reset is held, not just after the first edge.
  assign inst_sram.req   = resetn & (state == S_REQ) & (~buf_valid | drain);
  assign inst_sram.addr  = fetch_pc;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'b10;
  assign inst_sram.wstrb = '0;
  assign inst_sram.wdata = '0;

  assign IF_to_ID_Valid = buf_valid & ~br_taken;
  assign IF_to_ID_Bus   = {buf_pc, buf_inst};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      cancel    <= 1'b0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_inst  <= '0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      req_pc    <= req_pc_nxt;
      cancel    <= cancel_nxt;
      buf_valid <= buf_valid_nxt;
      buf_pc    <= buf_pc_nxt;
      buf_inst  <= buf_inst_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    req_pc_nxt    = req_pc;
    cancel_nxt    = cancel;
    buf_valid_nxt = buf_valid;
    buf_pc_nxt    = buf_pc;
    buf_inst_nxt  = buf_inst;

    // Drain only happens in S_REQ with a full buffer, so it never races a refill.
    if (drain) begin
      buf_valid_nxt = 1'b0;
    end

    unique case (state)
      S_REQ: begin
        if (addr_hs) begin
          state_nxt    = S_WAIT;
          req_pc_nxt   = fetch_pc;
          fetch_pc_nxt = fetch_pc + 32'd4;
        end
      end
      S_WAIT: begin
        if (inst_sram.data_ok) begin
          state_nxt = S_REQ;
          if (cancel) begin
            cancel_nxt = 1'b0;
          end else if (!br_taken) begin
            buf_valid_nxt = 1'b1;
            buf_pc_nxt    = req_pc;
            buf_inst_nxt  = inst_sram.rdata;
          end
        end
      end
      default: state_nxt = S_REQ;
    endcase

    // Redirect wins over every other update this cycle.
    if (br_taken) begin
      buf_valid_nxt = 1'b0;
      fetch_pc_nxt  = br_target;
      if (addr_hs) begin
        cancel_nxt = 1'b1;
      end else if (data_ret) begin
        cancel_nxt = 1'b0;
      end else if (state == S_WAIT) begin
        cancel_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: randomized memory/decode behaviour checked against
// a queue-based model of requests, in-flight responses and the decode buffer.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  logic        clk;
  logic        resetn;
  logic        ID_Allow_in;
  logic [33:0] br_bus;
  logic        IF_to_ID_Valid;
  logic [63:0] IF_to_ID_Bus;

  if_fetch_unit_if inst_sram ();

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .ID_Allow_in   (ID_Allow_in),
    .br_bus        (br_bus),
    .IF_to_ID_Valid(IF_to_ID_Valid),
    .IF_to_ID_Bus  (IF_to_ID_Bus),
    .inst_sram     (inst_sram.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int cyc;
  int allow_mode;
  int aok_mode;
  int dly_lo;
  int dly_hi;

  logic [31:0] mem_addr[$];
  int          mem_cnt[$];

  logic [31:0] m_fetch_pc;
  logic [31:0] m_out_pc[$];
  bit          m_out_stale[$];
  logic [63:0] m_buf[$];

  logic [31:0] dut_pcs[$];
  int          dut_cycs[$];

  logic        s_req, s_valid, s_hs, s_dok;
  logic [31:0] s_addr;
  logic [63:0] s_bus;
  logic [97:0] s_vec, e_vec;

  task automatic model_reset();
    m_fetch_pc = RESET_PC;
    m_out_pc.delete();
    m_out_stale.delete();
    m_buf.delete();
    mem_addr.delete();
    mem_cnt.delete();
  endtask

  // Drives one cycle (memory, decode, branch), samples the DUT and advances the model.
  task automatic run_cycle(input bit br, input logic [31:0] tgt);
    bit          drain, e_req, e_valid, fill;
    logic [31:0] fill_pc;
    logic [63:0] e_bus;
    fill_pc = '0;
    if (mem_addr.size() != 0 && mem_cnt[0] == 0) begin
      inst_sram.data_ok = 1'b1;
      inst_sram.rdata   = mem_addr[0] ^ 32'hFFFF_0000;
    end else begin
      inst_sram.data_ok = 1'b0;
      inst_sram.rdata   = $urandom;
    end
    inst_sram.addr_ok = (aok_mode == 2) ? ($urandom_range(0, 9) < 6) : (aok_mode != 0);
    ID_Allow_in       = (allow_mode == 2) ? ($urandom_range(0, 3) != 0) : (allow_mode != 0);
    br_bus            = {br, tgt, 1'($urandom_range(0, 1))};
    #2;
    s_req   = inst_sram.req;
    s_addr  = inst_sram.addr;
    s_valid = IF_to_ID_Valid;
    s_bus   = IF_to_ID_Bus;
    s_hs    = s_req & inst_sram.addr_ok;
    s_dok   = inst_sram.data_ok;

    drain   = (m_buf.size() != 0) && ID_Allow_in && !br;
    e_req   = (m_out_pc.size() == 0) && ((m_buf.size() == 0) || drain);
    e_valid = (m_buf.size() != 0) && !br;
    e_bus   = (m_buf.size() != 0) ? m_buf[0] : 64'h0;
    s_vec   = {s_req, s_req ? s_addr : 32'h0, s_valid, s_valid ? s_bus : 64'h0};
    e_vec   = {e_req, e_req ? m_fetch_pc : 32'h0, e_valid, e_valid ? e_bus : 64'h0};
    if (s_valid && ID_Allow_in) begin
      dut_pcs.push_back(s_bus[63:32]);
      dut_cycs.push_back(cyc);
    end

    if (s_dok) begin
      void'(mem_addr.pop_front());
      void'(mem_cnt.pop_front());
    end else if (mem_cnt.size() != 0) begin
      mem_cnt[0] = mem_cnt[0] - 1;
    end
    if (s_hs) begin
      mem_addr.push_back(s_addr);
      mem_cnt.push_back(int'($urandom_range(dly_lo, dly_hi)));
    end

    fill = 1'b0;
    if (s_dok && m_out_pc.size() != 0) begin
      fill_pc = m_out_pc.pop_front();
      fill    = !m_out_stale.pop_front() && !br;
    end
    if (drain || br) m_buf.delete();
    if (br) foreach (m_out_stale[i]) m_out_stale[i] = 1'b1;
    if (fill) m_buf.push_back({fill_pc, fill_pc ^ 32'hFFFF_0000});
    if (e_req && inst_sram.addr_ok) begin
      m_out_pc.push_back(m_fetch_pc);
      m_out_stale.push_back(br);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (br) m_fetch_pc = tgt;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    resetn            = 1'b0;
    ID_Allow_in       = 1'b0;
    br_bus            = '0;
    inst_sram.addr_ok = 1'b0;
    inst_sram.data_ok = 1'b0;
    inst_sram.rdata   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (inst_sram.req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_req got=%b want=0", inst_sram.req);
    end
    n_cmp++;
    if (IF_to_ID_Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid got=%b want=0", IF_to_ID_Valid);
    end
    n_cmp++;
    if (IF_to_ID_Bus !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_bus got=%h want=0", IF_to_ID_Bus);
    end
    resetn = 1'b1;
  endtask

  task automatic test_stream();
    allow_mode = 1; aok_mode = 1; dly_lo = 0; dly_hi = 0;
    dut_pcs.delete();
    dut_cycs.delete();
    for (int k = 0; k < 8; k++) begin
      run_cycle(1'b0, '0);
      n_cmp++;
      if (s_vec !== e_vec) begin
        n_bad++;
        $display("FAIL stream cyc=%0d got=%h want=%h", cyc, s_vec, e_vec);
      end
    end
    n_cmp++;
    if ({inst_sram.wr, inst_sram.size, inst_sram.wstrb, inst_sram.wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL const_fields got=%b/%b/%h/%h want=0/10/0/0",
               inst_sram.wr, inst_sram.size, inst_sram.wstrb, inst_sram.wdata);
    end
    n_cmp++;
    if (dut_pcs.size() != 3) begin
      n_bad++;
      $display("FAIL stream_count got=%0d want=3", dut_pcs.size());
    end
    for (int k = 0; k < dut_pcs.size() && k < 3; k++) begin
      n_cmp++;
      if (dut_pcs[k] !== RESET_PC + 32'(4 * k)) begin
        n_bad++;
        $display("FAIL stream_pc%0d got=%h want=%h", k, dut_pcs[k], RESET_PC + 32'(4 * k));
      end
      if (k > 0) begin
        n_cmp++;
        if (dut_cycs[k] - dut_cycs[k-1] != 2) begin
          n_bad++;
          $display("FAIL stream_spacing%0d got=%0d want=2", k, dut_cycs[k] - dut_cycs[k-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] cap;
    int          k;
    allow_mode = 0;
    k = 0;
    do begin
      run_cycle(1'b0, '0);
      n_cmp++;
      if (s_vec !== e_vec) begin
        n_bad++;
        $display("FAIL bp_fill cyc=%0d got=%h want=%h", cyc, s_vec, e_vec);
      end
      k++;
    end while (!s_valid && k < 10);
    n_cmp++;
    if (s_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_valid_timeout got=%b want=1", s_valid);
    end
    cap = s_bus;
    for (int j = 0; j < 5; j++) begin
      run_cycle(1'b0, '0);
      n_cmp++;
      if ({s_valid, s_req, s_bus} !== {1'b1, 1'b0, cap}) begin
        n_bad++;
        $display("FAIL bp_hold cyc=%0d got=%b/%b/%h want=1/0/%h", cyc, s_valid, s_req, s_bus, cap);
      end
    end
    allow_mode = 1;
    run_cycle(1'b0, '0);
    n_cmp++;
    if ({s_req, s_addr} !== {1'b1, cap[63:32] + 32'd4}) begin
      n_bad++;
      $display("FAIL bp_resume got=%b/%h want=1/%h", s_req, s_addr, cap[63:32] + 32'd4);
    end
  endtask

  // Waits for a handshake, optionally with a full buffer, then redirects and checks the next pc.
  task automatic test_branch_wait(input logic [31:0] tgt, input int dly);
    int          k;
    logic [31:0] got;
    allow_mode = 1; aok_mode = 1; dly_lo = dly; dly_hi = dly;
    k = 0;
    do begin
      run_cycle(1'b0, '0);
      n_cmp++;
      if (s_vec !== e_vec) begin
        n_bad++;
        $display("FAIL br_pre cyc=%0d got=%h want=%h", cyc, s_vec, e_vec);
      end
      k++;
    end while (!s_hs && k < 10);
    n_cmp++;
    if (s_hs !== 1'b1) begin
      n_bad++;
      $display("FAIL br_hs_timeout got=%b want=1", s_hs);
    end
    dut_pcs.delete();
    run_cycle(1'b1, tgt);
    k = 0;
    do begin
      n_cmp++;
      if (s_vec !== e_vec) begin
        n_bad++;
        $display("FAIL br_post cyc=%0d got=%h want=%h", cyc, s_vec, e_vec);
      end
      run_cycle(1'b0, '0);
      k++;
    end while (dut_pcs.size() == 0 && k < 25);
    got = (dut_pcs.size() != 0) ? dut_pcs[0] : 32'hDEAD_DEAD;
    n_cmp++;
    if (got !== tgt) begin
      n_bad++;
      $display("FAIL br_target_pc got=%h want=%h", got, tgt);
    end
  endtask

  task automatic test_branch_hs();
    int          k;
    logic [31:0] got;
    allow_mode = 0; aok_mode = 1; dly_lo = 2; dly_hi = 2;
    k = 0;
    do begin
      run_cycle(1'b0, '0);
      k++;
    end while (!s_valid && k < 10);
    aok_mode = 0;
    run_cycle(1'b1, 32'h1C00_0280);
    n_cmp++;
    if ({s_req, s_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL brhs_full got=%b/%b want=0/0", s_req, s_valid);
    end
    allow_mode = 1; aok_mode = 1;
    dut_pcs.delete();
    run_cycle(1'b1, 32'h1C00_0300);
    n_cmp++;
    if ({s_hs, s_addr} !== {1'b1, 32'h1C00_0280}) begin
      n_bad++;
      $display("FAIL brhs_accept got=%b/%h want=1/1c000280", s_hs, s_addr);
    end
    k = 0;
    do begin
      run_cycle(1'b0, '0);
      n_cmp++;
      if (s_vec !== e_vec) begin
        n_bad++;
        $display("FAIL brhs_post cyc=%0d got=%h want=%h", cyc, s_vec, e_vec);
      end
      k++;
    end while (dut_pcs.size() == 0 && k < 20);
    got = (dut_pcs.size() != 0) ? dut_pcs[0] : 32'hDEAD_DEAD;
    n_cmp++;
    if (got !== 32'h1C00_0300) begin
      n_bad++;
      $display("FAIL brhs_target_pc got=%h want=1c000300", got);
    end
  endtask

  task automatic test_stall();
    int          k, nhs;
    logic [31:0] cap;
    allow_mode = 1; aok_mode = 0; dly_lo = 0; dly_hi = 0;
    k = 0;
    do begin
      run_cycle(1'b0, '0);
      k++;
    end while (!s_req && k < 10);
    cap = s_addr;
    nhs = int'(s_hs);
    for (int j = 0; j < 4; j++) begin
      run_cycle(1'b0, '0);
      nhs += int'(s_hs);
      n_cmp++;
      if ({s_req, s_addr} !== {1'b1, cap}) begin
        n_bad++;
        $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/%h", cyc, s_req, s_addr, cap);
      end
    end
    aok_mode = 1;
    dut_pcs.delete();
    run_cycle(1'b0, '0);
    nhs += int'(s_hs);
    n_cmp++;
    if (nhs != 1) begin
      n_bad++;
      $display("FAIL stall_handshakes got=%0d want=1", nhs);
    end
    k = 0;
    while (dut_pcs.size() < 2 && k < 20) begin
      run_cycle(1'b0, '0);
      k++;
    end
    n_cmp++;
    if (dut_pcs.size() < 2 || dut_pcs[0] !== cap || dut_pcs[1] !== cap + 32'd4) begin
      n_bad++;
      $display("FAIL stall_seq got_n=%0d want=%h,%h", dut_pcs.size(), cap, cap + 32'd4);
    end
  endtask

  task automatic test_random();
    bit prev_br, br;
    allow_mode = 2; aok_mode = 2; dly_lo = 0; dly_hi = 3;
    prev_br = 1'b0;
    for (int k = 0; k < 600; k++) begin
      br = !prev_br && ($urandom_range(0, 11) == 0);
      run_cycle(br, $urandom);
      prev_br = br;
      n_cmp++;
      if (s_vec !== e_vec) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, s_vec, e_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    allow_mode = 1; aok_mode = 1; dly_lo = 3; dly_hi = 3;
    k = 0;
    do begin
      run_cycle(1'b0, '0);
      k++;
    end while (!s_hs && k < 12);
    run_cycle(1'b0, '0);
    #3;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({inst_sram.req, IF_to_ID_Valid, IF_to_ID_Bus} !== 66'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs got=%b/%b/%h want=0/0/0", inst_sram.req, IF_to_ID_Valid, IF_to_ID_Bus);
    end
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    dly_lo = 0; dly_hi = 0;
    run_cycle(1'b0, '0);
    n_cmp++;
    if ({s_req, s_addr} !== {1'b1, RESET_PC}) begin
      n_bad++;
      $display("FAIL midreset_restart got=%b/%h want=1/%h", s_req, s_addr, RESET_PC);
    end
    for (int j = 0; j < 6; j++) begin
      run_cycle(1'b0, '0);
      n_cmp++;
      if (s_vec !== e_vec) begin
        n_bad++;
        $display("FAIL midreset_post cyc=%0d got=%h want=%h", cyc, s_vec, e_vec);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    allow_mode = 1; aok_mode = 1; dly_lo = 0; dly_hi = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_wait(32'h1C00_0100, 3);
    test_branch_wait(32'h1C00_0200, 0);
    test_branch_hs();
    test_stall();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
